fetch_unit: RTL and testbench

Instruction fetch stage of the RV32 core, directly upstream of `Decoder`. It holds the program counter and issues word-aligned fetch requests to instruction memory over a valid/ready request channel with an in-order response channel. Returned words go into a small instruction buffer and are presented to the decoder with their PC over a valid/ready handshake. A redirect input, driven by branch, jump or trap resolution, flushes the buffer and in-flight fetches and restarts at a new PC.

---
 rtl/core_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types for the RV32 core front end.
// Provides xlen_t, fetch_state_e and NOP_INSTR; no ports.
package core_pkg;

  typedef logic [31:0] xlen_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } fetch_state_e;

  localparam xlen_t NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, full/empty and count.
// Ports: clk, rst_n, flush, push/wdata, pop/rdata, full, empty, count.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when a pop frees the slot.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32 fetch stage; PC, imem request/response, instr buffer.
// Ports: clk, rst_n, imem_req_*, imem_rsp_*, redirect_*, instr_*; fetch_fault with FETCH_MISALIGN_EN.
module fetch_unit
  import core_pkg::*;
#(
  parameter xlen_t RESET_PC  = 32'h0000_0000,
  parameter int    BUF_DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  output logic  imem_req_valid,
  input  logic  imem_req_ready,
  output xlen_t imem_req_addr,
  input  logic  imem_rsp_valid,
  input  xlen_t imem_rsp_data,
  input  logic  redirect_valid,
  input  xlen_t redirect_pc,
  output logic  instr_valid,
  input  logic  instr_ready,
  output xlen_t instr,
  output xlen_t instr_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic  fetch_fault
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;

  fetch_state_e state_q, state_d;
  xlen_t        pc_q;
  xlen_t        redir_pc;
  xlen_t        head_pc;
  cnt_t         outst_q, outst_d;
  cnt_t         drop_q;
  cnt_t         occ;
  cnt_t         pcq_cnt;
  logic [CW:0]  credit;
  logic [63:0]  head;
  logic         acc, rsp_live, push, pop, misalign;
  logic         dq_full, dq_empty, pcq_full, pcq_empty;
  logic         unused_ok;

`ifdef FETCH_MISALIGN_EN
  assign misalign    = redirect_pc[1:0] != 2'b00;
  assign redir_pc    = redirect_pc;
  assign fetch_fault = state_q == FAULT;
  assign unused_ok   = ^{dq_full, pcq_cnt};
`else
  assign misalign  = 1'b0;
  assign redir_pc  = {redirect_pc[31:2], 2'b00};
  assign unused_ok = ^{dq_full, pcq_cnt, redirect_pc[1:0]};
`endif

  assign pop    = instr_valid && instr_ready;
  assign credit = {1'b0, outst_q} + {1'b0, occ};

  // A slot popped this cycle is free for the word this request returns.
  assign imem_req_valid = (state_q == RUN) && !pcq_full &&
    (credit < (CW+1)'(BUF_DEPTH) + (CW+1)'(pop));
  assign imem_req_addr  = {pc_q[31:2], 2'b00};

  assign acc      = imem_req_valid && imem_req_ready;
  assign rsp_live = imem_rsp_valid && (drop_q == '0);
  assign push     = rsp_live && !redirect_valid && !pcq_empty;

  // Every outstanding request after a redirect is stale, whether or not
  // this cycle's response was already being dropped.
  assign outst_d = outst_q + cnt_t'(acc) - cnt_t'(imem_rsp_valid);

  fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_pcq (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (acc && !redirect_valid),
    .wdata (imem_req_addr),
    .pop   (push),
    .rdata (head_pc),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_cnt)
  );

  fetch_fifo #(.WIDTH(64), .DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .wdata ({head_pc, imem_rsp_data}),
    .pop   (pop),
    .rdata (head),
    .full  (dq_full),
    .empty (dq_empty),
    .count (occ)
  );

  assign instr_valid = !dq_empty;
  assign instr_pc    = head[63:32];
  assign instr       = head[31:0];

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      redirect_valid && misalign:  state_d = FAULT;
      redirect_valid && !misalign: state_d = RUN;
      !redirect_valid && (state_q == BOOT): state_d = RUN;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      if (redirect_valid) begin
        pc_q   <= redir_pc;
        drop_q <= outst_d;
      end else begin
        if (acc) begin
          pc_q <= pc_q + 32'd4;
        end
        if (imem_rsp_valid && (drop_q != '0)) begin
          drop_q <= drop_q - cnt_t'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Drives a 1-cycle in-order memory model and a decoder; second DUT checks PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        mem_hold;

  logic        w_req_valid, w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_instr_valid, w_instr_ready;
  logic [31:0] w_instr, w_instr_pc;
`ifdef FETCH_MISALIGN_EN
  logic        fault, w_fault;
`endif

  int n_pass = 0;
  int n_total = 0;
  int base_idx = 0;
  int simul_idx = 0;

  logic [31:0] pend[$], req_log[$];
  logic [63:0] got[$];
  logic [31:0] w_pend[$], w_log[$];
  logic [63:0] w_got[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_fault    (fault)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_w (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (w_req_ready),
    .imem_req_addr  (w_req_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .instr_valid    (w_instr_valid),
    .instr_ready    (w_instr_ready),
    .instr          (w_instr),
    .instr_pc       (w_instr_pc)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_fault    (w_fault)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h008500B3;
  endfunction

  function automatic logic [63:0] ent(input logic [31:0] a);
    return {a, word(a)};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      pend.delete();
      w_pend.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back(imem_req_addr);
        req_log.push_back(imem_req_addr);
      end
      if (instr_valid && instr_ready) got.push_back({instr_pc, instr});
      if (w_req_valid && w_req_ready) begin
        w_pend.push_back(w_req_addr);
        w_log.push_back(w_req_addr);
      end
      if (w_instr_valid && w_instr_ready) w_got.push_back({w_instr_pc, w_instr});
    end
  end

  always @(negedge clk) begin
    if (!mem_hold && pend.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    if (w_pend.size() != 0) begin
      w_rsp_valid = 1'b1;
      w_rsp_data  = word(w_pend.pop_front());
    end else begin
      w_rsp_valid = 1'b0;
      w_rsp_data  = '0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    n_total++;
    if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", imem_req_valid);
    else n_pass++;
    n_total++;
    if (imem_req_addr !== 32'h0) $display("FAIL rst_req_addr: got %h want 0", imem_req_addr);
    else n_pass++;
    n_total++;
    if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b want 0", instr_valid);
    else n_pass++;
    n_total++;
    if (instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", instr);
    else n_pass++;
    n_total++;
    if (instr_pc !== 32'h0) $display("FAIL rst_instr_pc: got %h want 0", instr_pc);
    else n_pass++;
    n_total++;
    if (w_req_addr !== 32'hFFFF_FFF8) $display("FAIL rst_wrap_addr: got %h want fffffff8", w_req_addr);
    else n_pass++;
`ifdef FETCH_MISALIGN_EN
    n_total++;
    if (fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", fault);
    else n_pass++;
`endif
  endtask

  task automatic test_boot();
    rst_n = 1'b1;
    n_total++;
    if (imem_req_valid !== 1'b0) $display("FAIL boot_cycle_idle: got %b want 0", imem_req_valid);
    else n_pass++;
    cyc(1);
    n_total++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0})
      $display("FAIL boot_first_req: got %b/%h want 1/0", imem_req_valid, imem_req_addr);
    else n_pass++;
    cyc(2);
    n_total++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, 32'h008500B3})
      $display("FAIL boot_first_instr: got %b/%h/%h want 1/0/008500b3", instr_valid, instr_pc, instr);
    else n_pass++;
    cyc(4);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (req_log.size() <= i) $display("FAIL boot_req_addr%0d: got none want %h", i, 4 * i);
      else if (req_log[i] !== 32'(4 * i))
        $display("FAIL boot_req_addr%0d: got %h want %h", i, req_log[i], 4 * i);
      else n_pass++;
      n_total++;
      if (got.size() <= i) $display("FAIL boot_deliver%0d: got none want %h", i, ent(32'(4 * i)));
      else if (got[i] !== ent(32'(4 * i)))
        $display("FAIL boot_deliver%0d: got %h want %h", i, got[i], ent(32'(4 * i)));
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] hold_exp;
    instr_ready = 1'b0;
    hold_exp = ent(32'(4 * got.size()));
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, hold_exp})
        $display("FAIL bp_stable%0d: got %b/%h want 1/%h", c, instr_valid, {instr_pc, instr}, hold_exp);
      else n_pass++;
      cyc(1);
    end
    n_total++;
    if (req_log.size() - got.size() !== 2)
      $display("FAIL bp_inflight: got %0d want 2", req_log.size() - got.size());
    else n_pass++;
    n_total++;
    if (imem_req_valid !== 1'b0) $display("FAIL bp_no_req: got %b want 0", imem_req_valid);
    else n_pass++;
    instr_ready = 1'b1;
    cyc(6);
    for (int i = 0; i < got.size(); i++) begin
      n_total++;
      if (got[i] !== ent(32'(4 * i)))
        $display("FAIL bp_seq%0d: got %h want %h", i, got[i], ent(32'(4 * i)));
      else n_pass++;
    end
  endtask

  task automatic test_redirect_inflight();
    mem_hold = 1'b1;
    cyc(5);
    n_total++;
    if ({imem_req_valid, instr_valid} !== 2'b00)
      $display("FAIL rd_two_inflight: got %b/%b want 0/0", imem_req_valid, instr_valid);
    else n_pass++;
    base_idx = got.size();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    cyc(1);
    redirect_valid = 1'b0;
    mem_hold = 1'b0;
    n_total++;
    if ({instr_valid, imem_req_valid, imem_req_addr} !== {2'b00, 32'h100})
      $display("FAIL rd_after: got %b/%b/%h want 0/0/100", instr_valid, imem_req_valid, imem_req_addr);
    else n_pass++;
    cyc(8);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (got.size() <= base_idx + k) $display("FAIL rd_deliver%0d: got none want %h", k, ent(32'h100 + 32'(4 * k)));
      else if (got[base_idx + k] !== ent(32'h100 + 32'(4 * k)))
        $display("FAIL rd_deliver%0d: got %h want %h", k, got[base_idx + k], ent(32'h100 + 32'(4 * k)));
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    int g0;
    logic [31:0] old_pc;
    cyc(3);
    n_total++;
    if ({instr_valid, imem_req_valid} !== 2'b11)
      $display("FAIL sim_stream: got %b/%b want 1/1", instr_valid, imem_req_valid);
    else n_pass++;
    g0 = got.size();
    old_pc = 32'h100 + 32'(4 * (g0 - base_idx));
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    cyc(1);
    redirect_valid = 1'b0;
    n_total++;
    if ({instr_valid, imem_req_valid, imem_req_addr} !== {2'b01, 32'h200})
      $display("FAIL sim_after: got %b/%b/%h want 0/1/200", instr_valid, imem_req_valid, imem_req_addr);
    else n_pass++;
    cyc(6);
    simul_idx = g0 + 1;
    n_total++;
    if (got.size() <= g0) $display("FAIL sim_pop_kept: got none want %h", ent(old_pc));
    else if (got[g0] !== ent(old_pc)) $display("FAIL sim_pop_kept: got %h want %h", got[g0], ent(old_pc));
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if (got.size() <= g0 + 1 + k) $display("FAIL sim_deliver%0d: got none want %h", k, ent(32'h200 + 32'(4 * k)));
      else if (got[g0 + 1 + k] !== ent(32'h200 + 32'(4 * k)))
        $display("FAIL sim_deliver%0d: got %h want %h", k, got[g0 + 1 + k], ent(32'h200 + 32'(4 * k)));
      else n_pass++;
    end
    n_total++;
    if (dut.drop_q !== '0) $display("FAIL sim_drop_cnt: got %0d want 0", dut.drop_q);
    else n_pass++;
  endtask

`ifdef FETCH_MISALIGN_EN
  task automatic test_misalign();
    int g1;
    cyc(3);
    g1 = got.size();
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    cyc(1);
    redirect_valid = 1'b0;
    n_total++;
    if ({fault, imem_req_valid, instr_valid} !== 3'b100)
      $display("FAIL mis_enter: got %b/%b/%b want 1/0/0", fault, imem_req_valid, instr_valid);
    else n_pass++;
    cyc(3);
    n_total++;
    if ({fault, imem_req_valid} !== 2'b10)
      $display("FAIL mis_hold: got %b/%b want 1/0", fault, imem_req_valid);
    else n_pass++;
    n_total++;
    if (got.size() !== g1 + 1) $display("FAIL mis_no_deliver: got %0d want %0d", got.size(), g1 + 1);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    cyc(1);
    redirect_valid = 1'b0;
    n_total++;
    if ({fault, imem_req_valid, imem_req_addr} !== {2'b01, 32'h200})
      $display("FAIL mis_resume: got %b/%b/%h want 0/1/200", fault, imem_req_valid, imem_req_addr);
    else n_pass++;
    cyc(6);
    n_total++;
    if (got.size() <= g1 + 1) $display("FAIL mis_deliver: got none want %h", ent(32'h200));
    else if (got[g1 + 1] !== ent(32'h200)) $display("FAIL mis_deliver: got %h want %h", got[g1 + 1], ent(32'h200));
    else n_pass++;
  endtask
`else
  task automatic test_misalign();
    int g1;
    logic [31:0] old_pc;
    cyc(3);
    g1 = got.size();
    old_pc = 32'h200 + 32'(4 * (g1 - simul_idx));
    redirect_valid = 1'b1;
    redirect_pc = 32'h302;
    cyc(1);
    redirect_valid = 1'b0;
    n_total++;
    if ({instr_valid, imem_req_valid, imem_req_addr} !== {2'b01, 32'h300})
      $display("FAIL align_after: got %b/%b/%h want 0/1/300", instr_valid, imem_req_valid, imem_req_addr);
    else n_pass++;
    cyc(6);
    n_total++;
    if (got.size() <= g1) $display("FAIL align_pop_kept: got none want %h", ent(old_pc));
    else if (got[g1] !== ent(old_pc)) $display("FAIL align_pop_kept: got %h want %h", got[g1], ent(old_pc));
    else n_pass++;
    n_total++;
    if (got.size() <= g1 + 1) $display("FAIL align_deliver: got none want %h", ent(32'h300));
    else if (got[g1 + 1] !== ent(32'h300)) $display("FAIL align_deliver: got %h want %h", got[g1 + 1], ent(32'h300));
    else n_pass++;
  endtask
`endif

  task automatic test_wrap();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8;
    exp_a[1] = 32'hFFFF_FFFC;
    exp_a[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (w_log.size() <= i) $display("FAIL wrap_req%0d: got none want %h", i, exp_a[i]);
      else if (w_log[i] !== exp_a[i]) $display("FAIL wrap_req%0d: got %h want %h", i, w_log[i], exp_a[i]);
      else n_pass++;
      n_total++;
      if (w_got.size() <= i) $display("FAIL wrap_deliver%0d: got none want %h", i, ent(exp_a[i]));
      else if (w_got[i] !== ent(exp_a[i]))
        $display("FAIL wrap_deliver%0d: got %h want %h", i, w_got[i], ent(exp_a[i]));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    n_total++;
    if ({imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc} !== {1'b0, 32'h0, 1'b0, 64'h0})
      $display("FAIL mid_reset: got %b/%h/%b/%h/%h want 0/0/0/0/0",
               imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc);
    else n_pass++;
    n_total++;
    if (dut.drop_q !== '0 || dut.outst_q !== '0)
      $display("FAIL mid_counters: got %0d/%0d want 0/0", dut.drop_q, dut.outst_q);
    else n_pass++;
    rst_n = 1'b1;
    n_total++;
    if (imem_req_valid !== 1'b0) $display("FAIL mid_boot: got %b want 0", imem_req_valid);
    else n_pass++;
    cyc(1);
    n_total++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0})
      $display("FAIL mid_restart: got %b/%h want 1/0", imem_req_valid, imem_req_addr);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    mem_hold = 1'b0;
    w_req_ready = 1'b1;
    w_redirect_valid = 1'b0;
    w_redirect_pc = '0;
    w_instr_ready = 1'b1;
    test_reset();
    test_boot();
    test_backpressure();
    test_redirect_inflight();
    test_simultaneous();
    test_misalign();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
